// File: rtl/clk_display_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_display_mux_if
// Brief    : Bundle of digit inputs, load/blink controls and the multiplexed
//            seven-segment outputs of the MM:SS display driver.
// Revision : 1.0 - initial release
// ============================================================================
interface clk_display_mux_if;
    logic       load;
    logic [3:0] min_ten;
    logic [3:0] min_one;
    logic [3:0] sec_ten;
    logic [3:0] sec_one;
    logic [3:0] blink_sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    // Digit source / controller side
    modport master (
        output load, min_ten, min_one, sec_ten, sec_one, blink_sel,
        input  an, seg, dp
    );

    // Display driver side
    modport slave (
        input  load, min_ten, min_one, sec_ten, sec_one, blink_sel,
        output an, seg, dp
    );
endinterface
`default_nettype wire

// File: rtl/clk_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : clk_display_mux
// Brief    : Four-digit multiplexed common-anode seven-segment driver with a
//            shadowed digit register, leading-zero blanking, per-digit blink
//            and a colon dot on digit 2.
// Revision : 1.0 - initial release
// ============================================================================
module clk_display_mux #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int LZ_BLANK     = 1
) (
    input  wire logic           clk,
    input  wire logic           reset,
    clk_display_mux_if.slave    bus
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SCAN_W-1:0]  C_SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] C_FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    // Digit index i lives in shadow slice [i]: 0=sec_one .. 3=min_ten
    logic [3:0][3:0]    shadow_q, shadow_d;
    logic [SCAN_W-1:0]  scan_q,   scan_d;
    logic [1:0]         idx_q,    idx_d;
    logic [FRAME_W-1:0] frame_q,  frame_d;
    logic               phase_q,  phase_d;
    logic [3:0]         an_q,     an_d;
    logic [6:0]         seg_q,    seg_d;
    logic               dp_q,     dp_d;

    logic [3:0]         digit_val;
    logic               blank;
    logic [6:0]         decoded;

    // Shadow capture plus scan / frame / blink-phase counters
    always_comb begin
        shadow_d = shadow_q;
        scan_d   = scan_q + SCAN_W'(1);
        idx_d    = idx_q;
        frame_d  = frame_q;
        phase_d  = phase_q;

        if (bus.load) begin
            shadow_d = {bus.min_ten, bus.min_one, bus.sec_ten, bus.sec_one};
        end

        if (scan_q == C_SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
            // Wrap from digit 3 back to digit 0 closes a frame
            if (idx_q == 2'd3) begin
                if (frame_q == C_FRAME_LAST) begin
                    frame_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + FRAME_W'(1);
                end
            end
        end
    end

    // Active-low BCD decode of the currently scanned digit
    always_comb begin
        digit_val = shadow_q[idx_q];
        case (digit_val)
            4'd0:    decoded = 7'h40;
            4'd1:    decoded = 7'h79;
            4'd2:    decoded = 7'h24;
            4'd3:    decoded = 7'h30;
            4'd4:    decoded = 7'h19;
            4'd5:    decoded = 7'h12;
            4'd6:    decoded = 7'h02;
            4'd7:    decoded = 7'h78;
            4'd8:    decoded = 7'h00;
            4'd9:    decoded = 7'h10;
            default: decoded = 7'h7F;
        endcase
    end

    // Next output image: blanking keeps the anode on, only segments go dark
    always_comb begin
        blank = (digit_val > 4'd9)
             || (bus.blink_sel[idx_q] && !phase_q)
             || ((LZ_BLANK != 0) && (idx_q == 2'd3) && (digit_val == 4'd0));
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank ? 7'h7F : decoded;
        dp_d  = !((idx_q == 2'd2) && phase_q);
    end

    // State and output registers; reset darkens the display immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            scan_q   <= '0;
            idx_q    <= 2'd0;
            frame_q  <= '0;
            phase_q  <= 1'b1;
            an_q     <= 4'hF;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            shadow_q <= shadow_d;
            scan_q   <= scan_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            phase_q  <= phase_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_display_mux
// Brief    : Randomized self-checking bench for clk_display_mux against a
//            time-based reference model of the display.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_display_mux;

    localparam int SD = 4;
    localparam int BF = 2;

    logic clk;
    logic reset;

    clk_display_mux_if bus();

    clk_display_mux #(
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF),
        .LZ_BLANK     (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Reference model: cycles since reset release and the displayed digits
    int         t = 0;
    logic [3:0] m_shadow [4];
    logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        else
            n_pass++;
    endtask

    // One clock: predict outputs from the model, clock, update model, compare
    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] v;
        int         idx;
        bit         ph;
        bit         blank;
        logic       s_rst, s_load;
        logic [3:0] s_digits [4];

        s_rst       = reset;
        s_load      = bus.load;
        s_digits[0] = bus.sec_one;
        s_digits[1] = bus.sec_ten;
        s_digits[2] = bus.min_one;
        s_digits[3] = bus.min_ten;

        if (s_rst) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            idx   = (t / SD) % 4;
            ph    = ((t / (4 * SD * BF)) % 2) == 0;
            v     = m_shadow[idx];
            blank = (v > 9) || (bus.blink_sel[idx] && !ph) || (idx == 3 && v == 0);
            e_an  = 4'hF;
            e_an[idx] = 1'b0;
            e_seg = blank ? 7'h7F : lut[v];
            e_dp  = (idx == 2 && ph) ? 1'b0 : 1'b1;
        end

        @(posedge clk);
        #1;
        cyc++;

        if (s_rst) begin
            t = 0;
            for (int i = 0; i < 4; i++) m_shadow[i] = 4'd0;
        end else begin
            t++;
            if (s_load)
                for (int i = 0; i < 4; i++) m_shadow[i] = s_digits[i];
        end

        check("an",  bus.an,  e_an);
        check("seg", bus.seg, e_seg);
        check("dp",  bus.dp,  e_dp);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m_shadow[i] = 4'd0;
        reset         = 1'b1;
        bus.load      = 1'b0;
        bus.min_ten   = 4'd0;
        bus.min_one   = 4'd0;
        bus.sec_ten   = 4'd0;
        bus.sec_one   = 4'd0;
        bus.blink_sel = 4'd0;

        // Reset state and the plain scan with an all-zero shadow
        repeat (2) step();
        reset = 1'b0;
        repeat (16) step();

        // Load 12:59
        bus.min_ten = 4'd1; bus.min_one = 4'd2;
        bus.sec_ten = 4'd5; bus.sec_one = 4'd9;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (16) step();

        // Inputs move without load: display must hold
        bus.min_ten = 4'($urandom_range(0, 9));
        bus.min_one = 4'($urandom_range(0, 9));
        bus.sec_ten = 4'($urandom_range(0, 9));
        bus.sec_one = 4'($urandom_range(0, 9));
        repeat (16) step();

        // Blink on the minute digits across several half-periods
        bus.blink_sel = 4'b1100;
        repeat (80) step();
        bus.blink_sel = 4'b0000;

        // Out-of-range digit blanks
        bus.sec_one = 4'hA;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (8) step();

        // Reset mid-digit together with load
        repeat (2) step();
        bus.min_ten = 4'd3; bus.sec_one = 4'd7;
        reset = 1'b1; bus.load = 1'b1;
        step();
        reset = 1'b0; bus.load = 1'b0;
        repeat (20) step();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            bus.load    = ($urandom % 6) == 0;
            bus.min_ten = 4'($urandom_range(0, 11));
            bus.min_one = 4'($urandom_range(0, 11));
            bus.sec_ten = 4'($urandom_range(0, 11));
            bus.sec_one = 4'($urandom_range(0, 11));
            if (($urandom % 40) == 0) bus.blink_sel = 4'($urandom);
            reset = ($urandom % 400) == 0;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_display_mux.md
# clk_display_mux

Four-digit multiplexed seven-segment driver for the clock simulator's MM:SS display. It consumes the BCD digits produced by the minute/second counter, holds them in a shadow register on a load strobe, and time-multiplexes them onto a common-anode display, one digit at a time. It also supports leading-zero blanking, per-digit blinking for time-set feedback, and a fixed colon dot.

## Interface
- SCAN_DIV, 50000: clk cycles each digit is driven; legal range ≥ 2.
- BLINK_FRAMES, 64: full 4-digit frames per blink half-period; legal range ≥ 1.
- LZ_BLANK, 1: when 1, blank the minute-tens digit while its value is 0.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- load  input  1  when high, capture all four digit inputs into the shadow register.
- min_ten  input  4  BCD minute tens.
- min_one  input  4  BCD minute ones.
- sec_ten  input  4  BCD second tens.
- sec_one  input  4  BCD second ones.
- blink_sel  input  4  per-digit blink enable; bit i maps to digit index i.
- an  output  4  digit enables, active-low, one-hot-low; an[i] enables digit index i.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low. Lit only on digit index 2 (colon).

## Operation
- Digit index map:
  - 0 = sec_one
  - 1 = sec_ten
  - 2 = min_one
  - 3 = min_ten
- Shadow register:
  - 4×4 bits, reset to 0.
  - On a clock with load=1, it takes all four inputs atomically.
  - Inputs are ignored while load=0.
- Scan counter:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and idx advances (3 wraps to 0).
  - A frame ends at the wrap from idx 3 to idx 0.
- Blink logic:
  - Frame counter counts 0..BLINK_FRAMES-1. At the end of a frame with frame count = BLINK_FRAMES-1, it wraps to 0 and `phase` toggles.
  - phase resets to 1 (visible).
- Blank condition for the current idx:
  - digit value > 9, or
  - blink_sel[idx]=1 and phase=0, or
  - LZ_BLANK=1 and idx=3 and value=0.
  - When blanked, seg=7'h7F, but an stays asserted for that digit.
- Decode table (hex, active-low):
  - 0→40, 1→79, 2→24, 3→30, 4→19
  - 5→12, 6→02, 7→78, 8→00, 9→10
- dp: 0 when idx=2 and phase=1; otherwise 1. The colon blinks with phase.
- blink_sel is combinational into the output register stage and is not shadowed.

## Timing
- Reset values:
  - an=4'hF, seg=7'h7F, dp=1
  - idx=0, scan count=0, frame count=0, phase=1, shadow=0
- an, seg and dp are registered. They reflect the idx, shadow and phase values from the previous cycle.
- First clock after reset deasserts: an=4'b1110, seg=7'h40 (shadow 0).
- Each digit is driven for exactly SCAN_DIV consecutive cycles. A frame is 4·SCAN_DIV cycles. A blink half-period is BLINK_FRAMES·4·SCAN_DIV cycles.
- Load latency: load sampled at edge N updates the shadow at N. If that digit is currently active, seg changes at edge N+1.
- Simultaneous events:
  - load together with reset: reset wins and the shadow clears.
  - load at an idx wrap: the new digit uses the new shadow value.
- Reset mid-scan: on the same edge, outputs go dark and all counters restart. No partial digit time is carried over.
- Steady state: exactly one an bit is low at any time.

## Test plan
- Reset with SCAN_DIV=4, BLINK_FRAMES=2, then release:
  - an sequence is 1110×4, 1101×4, 1011×4, 0111×4, then repeats.
  - seg=40 on indices 0–2; seg=7F on index 3 (LZ_BLANK).
- load with min=1,2 and sec=5,9:
  - Index 0 shows 10, index 1 shows 12, index 2 shows 24, index 3 shows 79.
  - dp=0 only on index 2.
- Change the inputs while load=0 → displayed values do not change.
- Pulse load while index 0 is active → seg updates exactly one cycle later.
- blink_sel=4'b1100, BLINK_FRAMES=2:
  - Indices 2–3 show seg=7F and dp=1 for 2 frames, then are visible for 2 frames.
  - Indices 0–1 are never blanked.
- Load sec_one=4'hA → index 0 shows seg=7F.
- Assert reset mid-digit while load=1:
  - Next cycle: an=F, seg=7F, shadow=0.
  - After release, the scan restarts at index 0.
